// File: rtl/fdtd_src_sched_if.sv
// Request/response bundle between the FDTD source scheduler, the field memory
// and the source-update datapath.
interface fdtd_src_sched_if #(
   parameter int FDTD_DATA_WIDTH = 32,
   parameter int ADDR_WIDTH      = 10
);
   logic                       start;
   logic                       abort;
   logic                       hold;
   logic [ADDR_WIDTH-1:0]      base_addr;
   logic [ADDR_WIDTH-1:0]      num_cells;
   logic                       rd_en;
   logic [ADDR_WIDTH-1:0]      rd_addr;
   logic [FDTD_DATA_WIDTH-1:0] rd_data;
   logic                       clken;
   logic [FDTD_DATA_WIDTH-1:0] Ez_c_o;
   logic [FDTD_DATA_WIDTH-1:0] Ez_n_i;
   logic                       wr_en;
   logic [ADDR_WIDTH-1:0]      wr_addr;
   logic [FDTD_DATA_WIDTH-1:0] wr_data;
   logic                       busy;
   logic                       done;
   logic [ADDR_WIDTH-1:0]      wr_count;

   modport slave (
      input  start, abort, hold, base_addr, num_cells, rd_data, Ez_n_i,
      output rd_en, rd_addr, clken, Ez_c_o, wr_en, wr_addr, wr_data,
             busy, done, wr_count
   );

   modport master (
      output start, abort, hold, base_addr, num_cells, rd_data, Ez_n_i,
      input  rd_en, rd_addr, clken, Ez_c_o, wr_en, wr_addr, wr_data,
             busy, done, wr_count
   );
endinterface

// File: rtl/fdtd_src_sched.sv
// Sweeps a run of source cells: reads each field value, feeds it through the
// enabled update datapath and writes the result back to the same address.
//
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | issuing one read per enabled cycle
//   DRAIN | all reads issued, waiting for in-flight cells to write back
//   DONE  | one-cycle completion pulse
module fdtd_src_sched #(
   parameter int FDTD_DATA_WIDTH = 32,
   parameter int ADDR_WIDTH      = 10,
   parameter int PIPE_LAT        = 3
) (
   input logic               CLK,
   input logic               RST,
   fdtd_src_sched_if.slave   bus
);
   localparam int DEPTH = 1 + PIPE_LAT;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t                     state, state_nxt;
   logic [ADDR_WIDTH-1:0]      base_q, num_q, idx_q, wr_count_q;
   logic [DEPTH-1:0]           vld_q;
   logic [ADDR_WIDTH-1:0]      adr_q [DEPTH];
   logic                       rd_en_d;
   logic [FDTD_DATA_WIDTH-1:0] ez_c_q;
   logic [ADDR_WIDTH-1:0]      rd_addr_raw;
   logic                       active, clken, kill, rd_en, wr_en;
   logic                       last_issue, drain_empty;

   always_comb begin
      active      = (state == RUN) || (state == DRAIN);
      clken       = active && !bus.hold;
      kill        = active && bus.abort;
      rd_en       = (state == RUN) && clken && !bus.abort;
      wr_en       = vld_q[PIPE_LAT] && clken && !bus.abort;
      rd_addr_raw = base_q + idx_q;
      last_issue  = (idx_q == num_q - ADDR_WIDTH'(1));
      // Empty after this edge: nothing behind the last stage, and the last stage
      // (if valid) is being written now.
      drain_empty = ~|vld_q[PIPE_LAT-1:0] && (clken || !vld_q[PIPE_LAT]);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (bus.start) state_nxt = (bus.num_cells == '0) ? DONE : RUN;
         RUN:   if (kill) state_nxt = IDLE;
                else if (rd_en && last_issue) state_nxt = DRAIN;
         DRAIN: if (kill) state_nxt = IDLE;
                else if (drain_empty) state_nxt = DONE;
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= IDLE;
         base_q     <= '0;
         num_q      <= '0;
         idx_q      <= '0;
         wr_count_q <= '0;
         rd_en_d    <= 1'b0;
         ez_c_q     <= '0;
      end else begin
         state   <= state_nxt;
         rd_en_d <= rd_en;
         if (rd_en_d) ez_c_q <= bus.rd_data;
         if (state == IDLE && bus.start) begin
            base_q     <= bus.base_addr;
            num_q      <= bus.num_cells;
            idx_q      <= '0;
            wr_count_q <= '0;
         end else begin
            if (rd_en) idx_q <= idx_q + ADDR_WIDTH'(1);
            if (wr_en) wr_count_q <= wr_count_q + ADDR_WIDTH'(1);
         end
      end
   end

   // In-flight tracker; stage 0 is the read just issued, stage PIPE_LAT writes back.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         vld_q <= '0;
         for (int i = 0; i < DEPTH; i++) adr_q[i] <= '0;
      end else if (kill) begin
         vld_q <= '0;
      end else if (clken) begin
         vld_q    <= {vld_q[PIPE_LAT-1:0], rd_en};
         adr_q[0] <= rd_addr_raw;
         for (int i = 1; i < DEPTH; i++) adr_q[i] <= adr_q[i-1];
      end
   end

   assign bus.rd_en    = rd_en;
   assign bus.rd_addr  = rd_en ? rd_addr_raw : '0;
   assign bus.clken    = clken;
   assign bus.Ez_c_o   = ez_c_q;
   assign bus.wr_en    = wr_en;
   assign bus.wr_addr  = wr_en ? adr_q[PIPE_LAT] : '0;
   assign bus.wr_data  = wr_en ? bus.Ez_n_i : '0;
   assign bus.busy     = active;
   assign bus.done     = (state == DONE);
   assign bus.wr_count = wr_count_q;

endmodule

// File: tb/tb_fdtd_src_sched.sv
// Directed bench for fdtd_src_sched: per-cycle activity masks and address
// sequences compared against hand-derived tables.
module tb_fdtd_src_sched;
   logic CLK;
   logic RST;

   fdtd_src_sched_if #(.FDTD_DATA_WIDTH(32), .ADDR_WIDTH(10)) bus ();

   fdtd_src_sched #(.FDTD_DATA_WIDTH(32), .ADDR_WIDTH(10), .PIPE_LAT(3)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus.slave)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Field memory returns data one cycle after the request; datapath result
   // is a fixed function of the address being written.
   logic [9:0] rd_addr_q;
   always @(posedge CLK) rd_addr_q <= bus.rd_addr;
   assign bus.rd_data = 32'h1000_0000 | {22'h0, rd_addr_q};
   assign bus.Ez_n_i  = {22'h0, bus.wr_addr} ^ 32'hA5A5_0000;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] m_rd, m_wr, m_done, m_busy, m_clk;
   logic [63:0] s_rd, s_wr;
   logic [31:0] first_wd, ezc3;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run(input int n, input logic [31:0] st, input logic [31:0] hd,
                      input logic [31:0] ab);
      bit got_wd;
      m_rd = '0; m_wr = '0; m_done = '0; m_busy = '0; m_clk = '0;
      s_rd = '0; s_wr = '0; first_wd = '0; ezc3 = '0; got_wd = 0;
      for (int c = 0; c < n; c++) begin
         @(negedge CLK);
         bus.start = st[c];
         bus.hold  = hd[c];
         bus.abort = ab[c];
         #1;
         m_rd[c]   = bus.rd_en;
         m_wr[c]   = bus.wr_en;
         m_done[c] = bus.done;
         m_busy[c] = bus.busy;
         m_clk[c]  = bus.clken;
         if (bus.rd_en) s_rd = {s_rd[53:0], bus.rd_addr};
         if (bus.wr_en) begin
            s_wr = {s_wr[53:0], bus.wr_addr};
            if (!got_wd) first_wd = bus.wr_data;
            got_wd = 1;
         end
         if (c == 3) ezc3 = bus.Ez_c_o;
      end
      bus.start = 1'b0;
      bus.hold  = 1'b0;
      bus.abort = 1'b0;
   endtask

   initial begin
      RST = 1'b0;
      bus.start = 1'b0; bus.abort = 1'b0; bus.hold = 1'b0;
      bus.base_addr = '0; bus.num_cells = '0;
      #2 RST = 1'b1;
      #2;
      chk("reset_ctrl", {bus.rd_en, bus.wr_en, bus.clken, bus.busy, bus.done}, 5'b0);
      chk("reset_data", {bus.Ez_c_o, bus.wr_count, bus.rd_addr, bus.wr_addr}, 64'h0);
      repeat (2) @(negedge CLK);
      RST = 1'b0;

      // Basic 4-cell sweep; second start at cycle 3 must be ignored
      bus.base_addr = 10'h010; bus.num_cells = 10'd4;
      run(12, 32'h9, 32'h0, 32'h0);
      chk("t1_rd_mask",   m_rd,   32'h01E);
      chk("t1_wr_mask",   m_wr,   32'h1E0);
      chk("t1_done_mask", m_done, 32'h200);
      chk("t1_busy_mask", m_busy, 32'h1FE);
      chk("t1_clken",     m_clk,  32'h1FE);
      chk("t1_rd_seq", s_rd, 64'({10'h010, 10'h011, 10'h012, 10'h013}));
      chk("t1_wr_seq", s_wr, 64'({10'h010, 10'h011, 10'h012, 10'h013}));
      chk("t1_wr_data", first_wd, 32'hA5A5_0010);
      chk("t1_ez_c",    ezc3,     32'h1000_0010);
      chk("t1_wr_count", bus.wr_count, 10'd4);

      // Hold for 2 cycles after the second read, and once more while draining
      run(15, 32'h1, 32'h118, 32'h0);
      chk("t2_rd_mask",   m_rd,   32'h066);
      chk("t2_wr_mask",   m_wr,   32'hE80);
      chk("t2_done_mask", m_done, 32'h1000);
      chk("t2_busy_mask", m_busy, 32'hFFE);
      chk("t2_clken",     m_clk,  32'hEE6);
      chk("t2_rd_seq", s_rd, 64'({10'h010, 10'h011, 10'h012, 10'h013}));
      chk("t2_wr_seq", s_wr, 64'({10'h010, 10'h011, 10'h012, 10'h013}));
      chk("t2_wr_count", bus.wr_count, 10'd4);

      // Address wrap; abort in IDLE (with start) and in DONE has no effect
      bus.base_addr = 10'h3FE; bus.num_cells = 10'd3;
      run(11, 32'h1, 32'h0, 32'h101);
      chk("t3_rd_mask",   m_rd,   32'h00E);
      chk("t3_wr_mask",   m_wr,   32'h0E0);
      chk("t3_done_mask", m_done, 32'h100);
      chk("t3_rd_seq", s_rd, 64'({10'h3FE, 10'h3FF, 10'h000}));
      chk("t3_wr_seq", s_wr, 64'({10'h3FE, 10'h3FF, 10'h000}));
      chk("t3_wr_data", first_wd, 32'hA5A5_03FE);
      chk("t3_wr_count", bus.wr_count, 10'd3);

      // Zero-length sweep
      bus.base_addr = 10'h055; bus.num_cells = 10'd0;
      run(4, 32'h1, 32'h0, 32'h0);
      chk("t4_rd_mask",   m_rd,   32'h0);
      chk("t4_wr_mask",   m_wr,   32'h0);
      chk("t4_busy_mask", m_busy, 32'h0);
      chk("t4_done_mask", m_done, 32'h2);
      chk("t4_wr_count", bus.wr_count, 10'd0);

      // Abort two cycles after start; start while busy ignored
      bus.base_addr = 10'h020; bus.num_cells = 10'd8;
      run(8, 32'h3, 32'h0, 32'h4);
      chk("t5_rd_mask",   m_rd,   32'h002);
      chk("t5_wr_mask",   m_wr,   32'h0);
      chk("t5_done_mask", m_done, 32'h0);
      chk("t5_busy_mask", m_busy, 32'h006);
      chk("t5_rd_seq", s_rd, 64'h020);
      chk("t5_wr_count", bus.wr_count, 10'd0);

      // Asynchronous reset in DRAIN
      bus.base_addr = 10'h010; bus.num_cells = 10'd4;
      run(7, 32'h1, 32'h0, 32'h0);
      chk("t6_wr_mask",   m_wr,   32'h060);
      chk("t6_busy_mask", m_busy, 32'h07E);
      chk("t6_wr_count_pre", bus.wr_count, 10'd1);
      #1 RST = 1'b1;
      #1;
      chk("t6_rst_ctrl", {bus.rd_en, bus.wr_en, bus.clken, bus.busy, bus.done}, 5'b0);
      chk("t6_rst_data", {bus.Ez_c_o, bus.wr_count, bus.rd_addr, bus.wr_addr}, 64'h0);
      chk("t6_rst_wdata", bus.wr_data, 32'h0);
      @(negedge CLK);
      RST = 1'b0;
      run(10, 32'h0, 32'h0, 32'h0);
      chk("t6_post_wr",   m_wr,   32'h0);
      chk("t6_post_done", m_done, 32'h0);
      chk("t6_post_busy", m_busy, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/fdtd_src_sched.md
FDTD_SRC_SCHED -- requirements
Module: fdtd_src_sched

Interface
REQ-001 SHALL have parameter FDTD_DATA_WIDTH, default 32, field/data word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, field-memory address width.
REQ-003 SHALL have parameter PIPE_LAT, default 3, enabled-cycle latency of the source-update datapath (Ez_c in -> Ez_n out), legal range 1..8.
REQ-004 CLK  input  1  single clock; all logic on rising edge.
REQ-005 RST  input  1  reset; asynchronous, active-high.
REQ-006 start  input  1  one-cycle pulse; begins a sweep.
REQ-007 abort  input  1  terminates the sweep in progress.
REQ-008 hold  input  1  downstream stall; freezes the sweep.
REQ-009 base_addr  input  ADDR_WIDTH  first source-cell address; sampled on accepted start.
REQ-010 num_cells  input  ADDR_WIDTH  number of cells to update; sampled on accepted start.
REQ-011 rd_en / rd_addr  output  1 / ADDR_WIDTH  field-memory read request; read data returns exactly 1 cycle later.
REQ-012 rd_data  input  FDTD_DATA_WIDTH  field-memory read data.
REQ-013 clken  output  1  datapath clock enable.
REQ-014 Ez_c_o  output  FDTD_DATA_WIDTH  current-field operand to the datapath.
REQ-015 Ez_n_i  input  FDTD_DATA_WIDTH  updated field from the datapath.
REQ-016 wr_en / wr_addr / wr_data  output  1 / ADDR_WIDTH / FDTD_DATA_WIDTH  field-memory write-back.
REQ-017 busy / done  output  1 / 1  sweep active; one-cycle completion pulse.
REQ-018 wr_count  output  ADDR_WIDTH  number of write-backs in the current/last sweep.

Function
REQ-019 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-020 IDLE: start=1 -> latch base_addr/num_cells, clear wr_count, go RUN; if num_cells=0 go DONE directly.
REQ-021 start SHALL be ignored in any state other than IDLE.
REQ-022 clken SHALL equal !hold in RUN and DRAIN, 0 in IDLE and DONE.
REQ-023 RUN: each cycle with clken=1 SHALL assert rd_en with rd_addr = base_addr + issue index (0,1,...), modulo 2^ADDR_WIDTH (wrap-around allowed).
REQ-024 After the read for index num_cells-1 is issued, FSM SHALL go DRAIN the next cycle; no further rd_en.
REQ-025 Ez_c_o SHALL register rd_data in the cycle after any rd_en, regardless of hold; otherwise hold its value.
REQ-026 A valid/address shift register of depth 1+PIPE_LAT SHALL track in-flight cells; it advances only when clken=1.
REQ-027 wr_en SHALL assert when the final stage is valid and clken=1; wr_addr = that cell's address; wr_data = Ez_n_i.
REQ-028 Total latency rd_en -> matching wr_en SHALL be 1+PIPE_LAT enabled cycles; hold cycles extend it 1:1.
REQ-029 hold=1 SHALL suppress rd_en and wr_en and freeze the issue index, shift register and wr_count.
REQ-030 wr_count SHALL increment by 1 on each wr_en.
REQ-031 DRAIN -> DONE when the shift register holds no valid entries; DONE lasts one cycle (done=1) then IDLE.
REQ-032 busy SHALL be 1 in RUN and DRAIN only.
REQ-033 abort=1 in RUN/DRAIN SHALL clear all valids, go IDLE next cycle without done, and produce no wr_en that cycle; abort overrides hold and start.
REQ-034 abort in IDLE or DONE SHALL have no effect.

Reset
REQ-035 RST=1 SHALL immediately force IDLE, clear valids, and set rd_en, wr_en, clken, busy, done, rd_addr, wr_addr, wr_data, Ez_c_o, wr_count to 0.
REQ-036 Reset mid-sweep SHALL discard all in-flight cells with no write-back after release.

Verification
REQ-037 start, base_addr=0x010, num_cells=4, hold=0, PIPE_LAT=3 -> rd_en 4 cycles (0x010..0x013); wr_en 4 cycles starting 4 cycles after first rd_en, same addresses; done 1 cycle after last write; wr_count=4.
REQ-038 Same sweep with hold=1 for 2 cycles after second read -> rd_addr sequence unchanged, each pending wr_en delayed 2 cycles, wr_count=4, no duplicated or lost addresses.
REQ-039 base_addr=0x3FE, num_cells=3 -> addresses 0x3FE, 0x3FF, 0x000 read and written.
REQ-040 num_cells=0 -> no rd_en/wr_en, busy stays 0, done pulses the cycle after start.
REQ-041 abort asserted 2 cycles after start (num_cells=8) -> no wr_en thereafter, no done, busy=0 next cycle; start while busy ignored.
REQ-042 RST pulsed mid-DRAIN -> all outputs 0 asynchronously; no wr_en after release until a new start.
